// File: rtl/countdown_arbiter.sv
// Purpose  : shares one WIDTH-bit down-counting timer between two requesters,
//            granting round-robin and pulsing the owner's done when it expires.
// Latency  : grant edge E loads lenX; count = lenX-i after E+i; doneX after
//            E+lenX+1; gntX drops after E+lenX+2 (grant spans lenX+2 cycles).
// Backpressure: a requester holds reqX until doneX; a non-owner request waits
//            while busy and is served in the first IDLE cycle after release.
//
// Ports:
//   clk_i            clock, all state updates on posedge
//   reset_i          asynchronous active-high reset
//   req0_i, len0_i   requester 0 request and count length (sampled on grant)
//   req1_i, len1_i   requester 1 request and count length (sampled on grant)
//   gnt0_o, gnt1_o   registered ownership flags, never both high
//   done0_o, done1_o one-cycle expiry pulses for the owner
//   busy_o           high whenever the FSM is not IDLE
//   count_o          registered counter value
module countdown_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             req0_i,
   input  logic [WIDTH-1:0] len0_i,
   input  logic             req1_i,
   input  logic [WIDTH-1:0] len1_i,
   output logic             gnt0_o,
   output logic             gnt1_o,
   output logic             done0_o,
   output logic             done1_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] count_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic             gnt0_q;
   logic             gnt1_q;
   logic             done0_q;
   logic             done1_q;
   logic             busy_q;
   logic [WIDTH-1:0] count_q;
   // Index of the requester most recently released; the other one wins a tie.
   logic             last_q;

   logic             pick1_d;
   logic             any_req_d;
   logic             owner_req_d;
   logic [WIDTH-1:0] grant_len_d;

   always_comb begin
      any_req_d   = req0_i | req1_i;
      // Requester 1 wins when alone, or when both ask and 0 was served last.
      pick1_d     = req1_i & (~req0_i | ~last_q);
      grant_len_d = pick1_d ? len1_i : len0_i;
      // Ownership is carried by the grant flags themselves.
      owner_req_d = gnt1_q ? req1_i : req0_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
         count_q <= '0;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               if (any_req_d) begin
                  state_q <= COUNT;
                  gnt0_q  <= ~pick1_d;
                  gnt1_q  <= pick1_d;
                  busy_q  <= 1'b1;
                  count_q <= grant_len_d;
               end
            end
            COUNT: begin
               if (!owner_req_d) begin
                  // Abort: release without a done pulse.
                  state_q <= IDLE;
                  gnt0_q  <= 1'b0;
                  gnt1_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  count_q <= '0;
                  last_q  <= gnt1_q;
               end else if (count_q != '0) begin
                  count_q <= count_q - WIDTH'(1);
               end else begin
                  // Zero guard: the counter parks at 0 instead of wrapping.
                  state_q <= DONE;
                  done0_q <= gnt0_q;
                  done1_q <= gnt1_q;
               end
            end
            DONE: begin
               state_q <= IDLE;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               busy_q  <= 1'b0;
               last_q  <= gnt1_q;
            end
            default: begin
               state_q <= IDLE;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               busy_q  <= 1'b0;
               count_q <= '0;
            end
         endcase
      end
   end

   assign gnt0_o  = gnt0_q;
   assign gnt1_o  = gnt1_q;
   assign done0_o = done0_q;
   assign done1_o = done1_q;
   assign busy_o  = busy_q;
   assign count_o = count_q;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Purpose  : self-checking bench for countdown_arbiter using per-cycle vectors
//            plus hand-written reset sequences.
// Latency  : each row drives inputs on a negedge and checks outputs 1 time
//            unit after the following posedge.
// Backpressure: none; the row table fixes every cycle, so no open-ended waits.
module tb_countdown_arbiter;

   logic       clk_i;
   logic       reset_i;
   logic       req0_i;
   logic [3:0] len0_i;
   logic       req1_i;
   logic [3:0] len1_i;
   logic       gnt0_o;
   logic       gnt1_o;
   logic       done0_o;
   logic       done1_o;
   logic       busy_o;
   logic [3:0] count_o;

   countdown_arbiter #(.WIDTH(4)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .req0_i  (req0_i),
      .len0_i  (len0_i),
      .req1_i  (req1_i),
      .len1_i  (len1_i),
      .gnt0_o  (gnt0_o),
      .gnt1_o  (gnt1_o),
      .done0_o (done0_o),
      .done1_o (done1_o),
      .busy_o  (busy_o),
      .count_o (count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Expected output word: {gnt0, gnt1, done0, done1, busy, count[3:0]}
   typedef struct {
      logic       r0;
      logic [3:0] l0;
      logic       r1;
      logic [3:0] l1;
      logic [8:0] e;
      int         tag;
      bit         pre_rst;
   } vec_t;

   vec_t       tbl[$];
   logic [8:0] exp_q[$];
   int         cur_tag;
   bit         rst_next;
   int         n_checks;
   int         n_fail;

   function automatic logic [8:0] ex(input logic g0, input logic g1,
                                     input logic d0, input logic d1,
                                     input logic [3:0] c);
      // busy is high exactly while a grant is held
      return {g0, g1, d0, d1, g0 | g1, c};
   endfunction

   function void add(input logic r0, input logic [3:0] l0,
                     input logic r1, input logic [3:0] l1,
                     input logic [8:0] e);
      vec_t v;
      v.r0 = r0; v.l0 = l0; v.r1 = r1; v.l1 = l1; v.e = e;
      v.tag = cur_tag;
      v.pre_rst = rst_next;
      rst_next = 1'b0;
      tbl.push_back(v);
   endfunction

   function automatic logic [8:0] outs();
      return {gnt0_o, gnt1_o, done0_o, done1_o, busy_o, count_o};
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [8:0] got, input logic [8:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s row%0d: got g0g1d0d1b=%b cnt=%0d, expected g0g1d0d1b=%b cnt=%0d",
                  name, idx, got[8:4], got[3:0], want[8:4], want[3:0]);
      end
   endtask

   task automatic step(input logic r0, input logic [3:0] l0,
                       input logic r1, input logic [3:0] l1,
                       input logic [8:0] e, input string name, input int idx);
      logic [8:0] want;
      @(negedge clk_i);
      req0_i = r0; len0_i = l0; req1_i = r1; len1_i = l1;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      want = exp_q.pop_front();
      chk(name, idx, outs(), want);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_i = 1'b1;
      req0_i = 1'b0; req1_i = 1'b0; len0_i = 4'd0; len1_i = 4'd0;
      @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_next = 1'b0;
      reset_i  = 1'b0;
      req0_i = 1'b0; req1_i = 1'b0; len0_i = 4'd0; len1_i = 4'd0;

      // ---- 1: single request, len0=3; len0 changed after grant is ignored
      cur_tag = 1;
      add(1, 3, 0, 0, ex(1, 0, 0, 0, 3));
      add(1, 7, 0, 0, ex(1, 0, 0, 0, 2));
      add(1, 7, 0, 0, ex(1, 0, 0, 0, 1));
      add(1, 7, 0, 0, ex(1, 0, 0, 0, 0));
      add(1, 7, 0, 0, ex(1, 0, 1, 0, 0));
      add(0, 7, 0, 0, ex(0, 0, 0, 0, 0));
      add(0, 7, 0, 0, ex(0, 0, 0, 0, 0));

      // ---- 2: contention from reset, req0 first, req1 next IDLE cycle
      cur_tag = 2; rst_next = 1'b1;
      add(1, 2, 1, 5, ex(1, 0, 0, 0, 2));
      add(1, 2, 1, 5, ex(1, 0, 0, 0, 1));
      add(1, 2, 1, 5, ex(1, 0, 0, 0, 0));
      add(1, 2, 1, 5, ex(1, 0, 1, 0, 0));
      add(0, 2, 1, 5, ex(0, 0, 0, 0, 0));
      add(0, 2, 1, 5, ex(0, 1, 0, 0, 5));
      add(0, 2, 1, 9, ex(0, 1, 0, 0, 4));
      add(0, 2, 1, 9, ex(0, 1, 0, 0, 3));
      add(0, 2, 1, 9, ex(0, 1, 0, 0, 2));
      add(0, 2, 1, 9, ex(0, 1, 0, 0, 1));
      add(0, 2, 1, 9, ex(0, 1, 0, 0, 0));
      add(0, 2, 1, 9, ex(0, 1, 0, 1, 0));
      add(0, 0, 0, 0, ex(0, 0, 0, 0, 0));

      // ---- 3: both held, len=1, grants alternate 0,1,0
      cur_tag = 3;
      for (int k = 0; k < 3; k++) begin
         logic g1;
         g1 = (k == 1);
         add(1, 1, 1, 1, ex(~g1, g1, 0, 0, 1));
         add(1, 1, 1, 1, ex(~g1, g1, 0, 0, 0));
         add(1, 1, 1, 1, ex(~g1, g1, ~g1, g1, 0));
         if (k < 2) add(1, 1, 1, 1, ex(0, 0, 0, 0, 0));
      end
      add(0, 0, 0, 0, ex(0, 0, 0, 0, 0));

      // ---- 4: zero length then max length on requester 1
      cur_tag = 4;
      add(0, 0, 1, 0, ex(0, 1, 0, 0, 0));
      add(0, 0, 1, 0, ex(0, 1, 0, 1, 0));
      add(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
      add(0, 0, 1, 15, ex(0, 1, 0, 0, 15));
      for (int i = 1; i <= 15; i++)
         add(0, 0, 1, 15, ex(0, 1, 0, 0, 4'(15 - i)));
      add(0, 0, 1, 15, ex(0, 1, 0, 1, 0));
      add(0, 0, 0, 15, ex(0, 0, 0, 0, 0));
      add(0, 0, 0, 15, ex(0, 0, 0, 0, 0));

      // ---- 5: abort of requester 0 at count=2, then requester 1 served
      cur_tag = 5;
      add(1, 5, 1, 3, ex(1, 0, 0, 0, 5));
      add(1, 5, 1, 3, ex(1, 0, 0, 0, 4));
      add(1, 5, 1, 3, ex(1, 0, 0, 0, 3));
      add(1, 5, 1, 3, ex(1, 0, 0, 0, 2));
      add(0, 5, 1, 3, ex(0, 0, 0, 0, 0));
      add(0, 5, 1, 3, ex(0, 1, 0, 0, 3));
      add(0, 5, 1, 3, ex(0, 1, 0, 0, 2));
      add(0, 5, 1, 3, ex(0, 1, 0, 0, 1));
      add(0, 5, 1, 3, ex(0, 1, 0, 0, 0));
      add(0, 5, 1, 3, ex(0, 1, 0, 1, 0));
      add(0, 0, 0, 0, ex(0, 0, 0, 0, 0));

      // ---- reset state, asserted between edges before the first clock
      #3 reset_i = 1'b1;
      #1 chk("reset_state", 0, outs(), 9'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;

      foreach (tbl[i]) begin
         if (tbl[i].pre_rst) do_reset();
         step(tbl[i].r0, tbl[i].l0, tbl[i].r1, tbl[i].l1, tbl[i].e,
              $sformatf("sec%0d", tbl[i].tag), i);
      end

      // ---- 6: async reset mid-COUNT; requester 1 owned, requester 0 last served
      step(1, 0, 0, 0, ex(1, 0, 0, 0, 0), "abort_setup", 0);
      step(1, 0, 0, 0, ex(1, 0, 1, 0, 0), "abort_setup", 1);
      step(0, 0, 0, 0, ex(0, 0, 0, 0, 0), "abort_setup", 2);
      step(0, 0, 1, 6, ex(0, 1, 0, 0, 6), "abort_setup", 3);
      step(0, 0, 1, 6, ex(0, 1, 0, 0, 5), "abort_setup", 4);
      step(0, 0, 1, 6, ex(0, 1, 0, 0, 4), "abort_setup", 5);
      step(0, 0, 1, 6, ex(0, 1, 0, 0, 3), "abort_setup", 6);
      #2 reset_i = 1'b1;
      #1 chk("async_reset_now", 0, outs(), 9'd0);
      req0_i = 1'b1; len0_i = 4'd4; len1_i = 4'd7;
      @(posedge clk_i);
      #1 chk("reset_held", 0, outs(), 9'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      req0_i = 1'b0; req1_i = 1'b0;
      step(1, 4, 1, 7, ex(1, 0, 0, 0, 4), "after_reset", 0);
      step(1, 4, 1, 7, ex(1, 0, 0, 0, 3), "after_reset", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
